// File: rtl/wb_mean_sched_if.sv
// Pixel-stream and mean-accumulator signals of the white-balance scheduler.
// Signal suffixes follow the scheduler's view; the slave modport is the scheduler side.
interface wb_mean_sched_if;
   logic       pix_valid_i;
   logic       pix_ready_o;
   logic [7:0] pix_value_i;
   logic       acc_rst_n_o;
   logic       acc_valid_o;
   logic [1:0] acc_color_o;
   logic [7:0] acc_value_o;
   logic       acc_last_o;
   logic [4:0] acc_size_o;
   logic       acc_finish_i;
   logic [7:0] acc_r_mean_i;
   logic [7:0] acc_g_mean_i;
   logic [7:0] acc_b_mean_i;

   modport slave (
      input  pix_valid_i, pix_value_i, acc_finish_i,
             acc_r_mean_i, acc_g_mean_i, acc_b_mean_i,
      output pix_ready_o, acc_rst_n_o, acc_valid_o, acc_color_o,
             acc_value_o, acc_last_o, acc_size_o
   );

   modport master (
      output pix_valid_i, pix_value_i, acc_finish_i,
             acc_r_mean_i, acc_g_mean_i, acc_b_mean_i,
      input  pix_ready_o, acc_rst_n_o, acc_valid_o, acc_color_o,
             acc_value_o, acc_last_o, acc_size_o
   );
endinterface

// File: rtl/wb_mean_sched.sv
// Frame scheduler for the white-balance mean accumulator: tags RGGB pixels,
// drops Gb, drives clear/last/size, then derives G/R and G/B gains serially.
module wb_mean_sched #(
   parameter int TIMEOUT = 15,
   parameter int GAIN_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [3:0]        log2_w_i,
   input  logic [3:0]        log2_h_i,
   output logic              busy_o,
   wb_mean_sched_if.slave    bus,
   output logic [GAIN_W-1:0] r_gain_o,
   output logic [GAIN_W-1:0] b_gain_o,
   output logic              done_o,
   output logic              err_o
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
   localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(256);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_STREAM, S_WAIT_FIN, S_DIV_R, S_DIV_B, S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [3:0]        lw_q, lh_q, it_q;
   logic [11:0]       col_q, row_q;
   logic [TW-1:0]     wait_q;
   logic [7:0]        r_mean_q, g_mean_q, b_mean_q, rem_q;
   logic [15:0]       quo_q;
   logic [GAIN_W-1:0] r_res_q, r_gain_q, b_gain_q;
   logic              busy_q, pix_ready_q, acc_rst_n_q, acc_valid_q, acc_last_q;
   logic              done_q, err_q;
   logic [1:0]        acc_color_q;
   logic [7:0]        acc_value_q;
   logic [4:0]        acc_size_q;

   logic              dims_ok, xfer, is_gb, col_last, row_last, last_pos;
   logic              timeout_hit, err_d, fits, div_end;
   logic [11:0]       col_max, row_max;
   logic [7:0]        divisor, rem_next;
   logic [8:0]        trial;
   logic [15:0]       quo_next;
   logic [GAIN_W-1:0] quo_sat;

   assign dims_ok = (log2_w_i >= 4'd1) && (log2_w_i <= 4'd12) &&
                    (log2_h_i >= 4'd1) && (log2_h_i <= 4'd12) &&
                    (({1'b0, log2_w_i} + {1'b0, log2_h_i}) <= 5'd22);

   assign col_max  = ~(12'hFFF << lw_q);
   assign row_max  = ~(12'hFFF << lh_q);
   assign col_last = (col_q == col_max);
   assign row_last = (row_q == row_max);
   assign xfer     = pix_ready_q && bus.pix_valid_i;
   assign is_gb    = row_q[0] && !col_q[0];
   // Final R and Gr share row H-2 (cols W-2, W-1); final B is the frame's last pixel.
   assign last_pos = ((row_q == row_max - 12'd1) && (col_q >= col_max - 12'd1)) ||
                     (row_last && col_last);

   assign timeout_hit = (wait_q == TW'(TIMEOUT - 1));
   assign err_d = (state_q == S_IDLE && start_i && !dims_ok) ||
                  (state_q == S_WAIT_FIN && !bus.acc_finish_i && timeout_hit);

   // One restoring-division step per cycle; the dividend shifts out of quo_q as quotient bits shift in.
   assign divisor  = (state_q == S_DIV_B) ? b_mean_q : r_mean_q;
   assign trial    = {rem_q, quo_q[15]};
   assign fits     = (trial >= {1'b0, divisor});
   assign quo_next = {quo_q[14:0], fits};
   assign rem_next = fits ? 8'(trial - {1'b0, divisor}) : trial[7:0];
   assign div_end  = (divisor == 8'd0) || (it_q == 4'd15);
   assign quo_sat  = ((divisor == 8'd0) || (quo_next > 16'(GAIN_MAX))) ? GAIN_MAX
                                                                      : quo_next[GAIN_W-1:0];

   // NOTE: every signal written here gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (start_i && dims_ok) state_d = S_CLR;
         S_CLR:      state_d = S_STREAM;
         S_STREAM:   if (xfer && row_last && col_last) state_d = S_WAIT_FIN;
         S_WAIT_FIN: if (bus.acc_finish_i) state_d = S_DIV_R;
                     else if (timeout_hit) state_d = S_IDLE;
         S_DIV_R:    if (div_end) state_d = S_DIV_B;
         S_DIV_B:    if (div_end) state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lw_q <= '0; lh_q <= '0; it_q <= '0; col_q <= '0; row_q <= '0; wait_q <= '0;
         r_mean_q <= '0; g_mean_q <= '0; b_mean_q <= '0; rem_q <= '0; quo_q <= '0;
         r_res_q <= GAIN_ONE; r_gain_q <= GAIN_ONE; b_gain_q <= GAIN_ONE;
         busy_q <= 1'b0; pix_ready_q <= 1'b0; acc_rst_n_q <= 1'b0; acc_valid_q <= 1'b0;
         acc_last_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
         acc_color_q <= '0; acc_value_q <= '0; acc_size_q <= '0;
      end else begin
         busy_q      <= (state_d != S_IDLE);
         pix_ready_q <= (state_d == S_STREAM);
         acc_rst_n_q <= (state_d != S_CLR);
         done_q      <= (state_d == S_DONE);
         err_q       <= err_d;
         acc_valid_q <= xfer && !is_gb;
         acc_last_q  <= xfer && last_pos;
         if (xfer && !is_gb) begin
            acc_color_q <= row_q[0] ? 2'd2 : {1'b0, col_q[0]};
            acc_value_q <= bus.pix_value_i;
         end
         unique case (state_q)
            S_IDLE: if (start_i && dims_ok) begin
               lw_q       <= log2_w_i;
               lh_q       <= log2_h_i;
               acc_size_q <= {1'b0, log2_w_i} + {1'b0, log2_h_i} - 5'd2;
            end
            S_CLR: begin
               col_q  <= '0;
               row_q  <= '0;
               wait_q <= '0;
            end
            S_STREAM: if (xfer) begin
               col_q <= col_last ? 12'd0 : col_q + 12'd1;
               if (col_last) row_q <= row_q + 12'd1;
            end
            S_WAIT_FIN: begin
               wait_q <= wait_q + TW'(1);
               if (bus.acc_finish_i) begin
                  r_mean_q <= bus.acc_r_mean_i;
                  g_mean_q <= bus.acc_g_mean_i;
                  b_mean_q <= bus.acc_b_mean_i;
                  quo_q    <= {bus.acc_g_mean_i, 8'h00};
                  rem_q    <= '0;
                  it_q     <= '0;
               end
            end
            S_DIV_R, S_DIV_B: begin
               if (div_end) begin
                  quo_q <= {g_mean_q, 8'h00};
                  rem_q <= '0;
                  it_q  <= '0;
                  if (state_q == S_DIV_R) begin
                     r_res_q <= quo_sat;
                  end else begin
                     r_gain_q <= r_res_q;
                     b_gain_q <= quo_sat;
                  end
               end else begin
                  quo_q <= quo_next;
                  rem_q <= rem_next;
                  it_q  <= it_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o          = busy_q;
   assign bus.pix_ready_o = pix_ready_q;
   assign bus.acc_rst_n_o = acc_rst_n_q;
   assign bus.acc_valid_o = acc_valid_q;
   assign bus.acc_color_o = acc_color_q;
   assign bus.acc_value_o = acc_value_q;
   assign bus.acc_last_o  = acc_last_q;
   assign bus.acc_size_o  = acc_size_q;
   assign r_gain_o        = r_gain_q;
   assign b_gain_o        = b_gain_q;
   assign done_o          = done_q;
   assign err_o           = err_q;
endmodule

// File: tb/tb_wb_mean_sched.sv
// Directed bench for wb_mean_sched: 4x4 RGGB frames against a model accumulator,
// stalls, saturation/divide-by-zero, bad dims, finish timeout and mid-frame reset.
module tb_wb_mean_sched;
   logic       clk = 1'b0;
   logic       rst;
   logic       start_i;
   logic [3:0] log2_w_i, log2_h_i;
   logic       busy_o, done_o, err_o;
   logic [9:0] r_gain_o, b_gain_o;

   int total = 0;
   int bad   = 0;
   int clr_cnt = 0;
   int clr_base, samp_base, lat;
   logic [10:0] samp_q[$];

   wb_mean_sched_if bus();

   wb_mean_sched #(.TIMEOUT(15), .GAIN_W(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .log2_w_i (log2_w_i),
      .log2_h_i (log2_h_i),
      .busy_o   (busy_o),
      .bus      (bus),
      .r_gain_o (r_gain_o),
      .b_gain_o (b_gain_o),
      .done_o   (done_o),
      .err_o    (err_o)
   );

   always #5 clk = ~clk;

   // Model accumulator front end: log forwarded samples and clear cycles.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.acc_valid_o) samp_q.push_back({bus.acc_last_o, bus.acc_color_o, bus.acc_value_o});
         if (!bus.acc_rst_n_o) clr_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pix_at(input int r, input int c);
      if ((r % 2 == 0) && (c % 2 == 0)) return 8'd100;
      if ((r % 2 == 1) && (c % 2 == 1)) return 8'd200;
      return 8'd50;
   endfunction

   task automatic check_reset(input string pfx);
      check({pfx, "_busy"},    busy_o, 0);
      check({pfx, "_ready"},   bus.pix_ready_o, 0);
      check({pfx, "_rst_n"},   bus.acc_rst_n_o, 0);
      check({pfx, "_valid"},   bus.acc_valid_o, 0);
      check({pfx, "_color"},   bus.acc_color_o, 0);
      check({pfx, "_value"},   bus.acc_value_o, 0);
      check({pfx, "_last"},    bus.acc_last_o, 0);
      check({pfx, "_size"},    bus.acc_size_o, 0);
      check({pfx, "_r_gain"},  r_gain_o, 256);
      check({pfx, "_b_gain"},  b_gain_o, 256);
      check({pfx, "_done"},    done_o, 0);
      check({pfx, "_err"},     err_o, 0);
   endtask

   // 4x4 frame; with do_fin the model returns means and lat counts cycles after the
   // finish edge until done_o, otherwise lat counts WAIT_FIN cycles until err_o.
   task automatic run_frame(input string tag, input bit stall, input bit do_fin,
                            input logic [7:0] rm, input logic [7:0] gm, input logic [7:0] bm);
      int idx, p;
      clr_base  = clr_cnt;
      samp_base = samp_q.size();
      @(negedge clk); start_i = 1'b1; log2_w_i = 4'd2; log2_h_i = 4'd2;
      @(negedge clk); start_i = 1'b0;
      idx = 0; p = 0;
      while (idx < 16 && p < 2000) begin
         @(negedge clk);
         bus.pix_valid_i = !stall || (p % 3 == 0);
         bus.pix_value_i = pix_at(idx / 4, idx % 4);
         if (bus.pix_valid_i && bus.pix_ready_o) idx++;
         p++;
      end
      check({tag, "_pixels_sent"}, idx, 16);
      @(negedge clk); bus.pix_valid_i = 1'b0;
      check({tag, "_ready_low"}, bus.pix_ready_o, 0);
      lat = 0;
      if (do_fin) begin
         bus.acc_r_mean_i = rm; bus.acc_g_mean_i = gm; bus.acc_b_mean_i = bm;
         bus.acc_finish_i = 1'b1;
         @(negedge clk); bus.acc_finish_i = 1'b0;
         while (!done_o && lat < 100) begin @(negedge clk); lat++; end
      end else begin
         while (!err_o && lat < 100) begin @(negedge clk); lat++; end
      end
   endtask

   task automatic check_samples(input string tag);
      logic [10:0] exp_q[$];
      logic [1:0]  color;
      logic        last;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!((r % 2 == 1) && (c % 2 == 0))) begin
               color = (r % 2 == 1) ? 2'd2 : ((c % 2 == 1) ? 2'd1 : 2'd0);
               last  = (r == 2 && c == 2) || (r == 2 && c == 3) || (r == 3 && c == 3);
               exp_q.push_back({last, color, pix_at(r, c)});
            end
         end
      end
      check({tag, "_n_samples"}, samp_q.size() - samp_base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (samp_base + i < samp_q.size())
            check($sformatf("%s_sample%0d", tag, i), samp_q[samp_base + i], exp_q[i]);
   endtask

   task automatic check_good(input string tag, input int exp_lat,
                             input int exp_r, input int exp_b);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_done"},    done_o, 1);
      check({tag, "_r_gain"},  r_gain_o, exp_r);
      check({tag, "_b_gain"},  b_gain_o, exp_b);
      check({tag, "_size"},    bus.acc_size_o, 2);
      check({tag, "_clr"},     clr_cnt - clr_base, 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, done_o, 0);
      check({tag, "_idle"},       busy_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start_i = 1'b0; log2_w_i = '0; log2_h_i = '0;
      bus.pix_valid_i = 1'b0; bus.pix_value_i = '0; bus.acc_finish_i = 1'b0;
      bus.acc_r_mean_i = '0; bus.acc_g_mean_i = '0; bus.acc_b_mean_i = '0;
      repeat (2) @(negedge clk);
      check_reset("por");
      rst = 1'b0;
      @(negedge clk);
      check("por_rst_n_release", bus.acc_rst_n_o, 1);

      run_frame("plain", 1'b0, 1'b1, 8'd100, 8'd50, 8'd200);
      check_samples("plain");
      check_good("plain", 32, 128, 64);

      run_frame("stall", 1'b1, 1'b1, 8'd100, 8'd50, 8'd200);
      check_samples("stall");
      check_good("stall", 32, 128, 64);

      run_frame("sat", 1'b0, 1'b1, 8'd10, 8'd200, 8'd0);
      check_good("sat", 17, 1023, 1023);

      clr_base = clr_cnt;
      @(negedge clk); start_i = 1'b1; log2_w_i = 4'd12; log2_h_i = 4'd12;
      @(negedge clk); start_i = 1'b0;
      check("bad24_err", err_o, 1);
      check("bad24_busy", busy_o, 0);
      @(negedge clk);
      check("bad24_err_pulse", err_o, 0);
      check("bad24_busy2", busy_o, 0);
      start_i = 1'b1; log2_w_i = 4'd0; log2_h_i = 4'd3;
      @(negedge clk); start_i = 1'b0;
      check("bad0_err", err_o, 1);
      check("bad0_busy", busy_o, 0);
      @(negedge clk);
      check("bad_clr", clr_cnt - clr_base, 0);

      run_frame("tmo", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      check("tmo_latency", lat, 15);
      check("tmo_err", err_o, 1);
      check("tmo_done", done_o, 0);
      check("tmo_r_gain", r_gain_o, 1023);
      check("tmo_b_gain", b_gain_o, 1023);
      @(negedge clk);
      check("tmo_err_pulse", err_o, 0);
      check("tmo_idle", busy_o, 0);

      start_i = 1'b1; log2_w_i = 4'd12; log2_h_i = 4'd10;
      @(negedge clk); start_i = 1'b0;
      check("big_busy", busy_o, 1);
      check("big_size", bus.acc_size_o, 20);
      bus.pix_valid_i = 1'b1;
      repeat (5) @(negedge clk);
      check("big_streaming", bus.pix_ready_o, 1);
      #2 rst = 1'b1;
      #1 check_reset("mid");
      @(negedge clk); bus.pix_valid_i = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("mid_rst_n_release", bus.acc_rst_n_o, 1);

      run_frame("after", 1'b0, 1'b1, 8'd100, 8'd50, 8'd200);
      check_samples("after");
      check_good("after", 32, 128, 64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_mean_sched.md
Name: wb_mean_sched

Overview:
Frame-level scheduler and gain engine for the per-channel mean accumulator in the white-balance path. It accepts a raw RGGB Bayer pixel stream through a valid/ready handshake and tags each pixel with its colour. It drops Gb so that R, Gr and B each contribute exactly N/4 samples. It clears the accumulator per frame, drives its three-pulse last protocol and size exponent, and waits for finish. It then computes gray-world gains G/R and G/B with a serial divider.

Parameters:
TIMEOUT, 15, cycles allowed in WAIT_FIN before error
GAIN_W, 10, gain width, unsigned Q2.8

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start_i  in  1  start frame, sampled in IDLE only
log2_w_i  in  4  log2 frame width
log2_h_i  in  4  log2 frame height
busy_o  out  1  high in every state except IDLE
pix_valid_i  in  1  pixel valid
pix_ready_o  out  1  pixel ready
pix_value_i  in  8  raw pixel, raster order, RGGB phase at (0,0)
acc_rst_n_o  out  1  active-low clear to accumulator
acc_valid_o  out  1  sample valid to accumulator
acc_color_o  out  2  0=R, 1=G, 2=B
acc_value_o  out  8  sample value
acc_last_o  out  1  last-sample pulse, one per channel
acc_size_o  out  5  shift exponent = log2_w+log2_h-2
acc_finish_i  in  1  accumulator done
acc_r_mean_i, acc_g_mean_i, acc_b_mean_i  in  8 each  channel means
r_gain_o, b_gain_o  out  GAIN_W each  gains, held until next done
done_o  out  1  one-cycle pulse, gains valid
err_o  out  1  one-cycle pulse on bad dims or timeout

Behaviour:
- Reset values: busy 0, pix_ready 0, acc_rst_n 0, acc_valid 0, acc_color 0, acc_value 0, acc_last 0, acc_size 0, gains 0x100 (1.0), done 0, err 0. All registered outputs; acc_rst_n goes 1 on the first clk after rst deasserts.
- FSM: IDLE -> CLR -> STREAM -> WAIT_FIN -> DIV_R -> DIV_B -> DONE -> IDLE.
- IDLE: on start_i, check dims: each in 1..12 and sum <= 22.
  - Bad dims: err_o pulses next cycle and the block stays in IDLE.
  - Good dims: latch dims, latch acc_size, go to CLR.
- CLR: exactly one cycle with acc_rst_n_o=0; row and col counters cleared.
- STREAM: pix_ready_o=1. A transfer occurs when valid&ready.
  - Colour: even row/even col=R; even/odd=G (Gr); odd/odd=B; odd/even=Gb.
  - Gb is accepted but forwarded with acc_valid_o=0.
  - Forwarded sample appears on acc_* one cycle after transfer; acc_valid_o=0 in cycles without a transfer.
  - Gaps in pix_valid_i stall the counters; there is no limit on gap length.
- acc_last_o pulses with the final sample of each channel: R at (H-2,W-2), Gr at (H-2,W-1), B at (H-1,W-1).
- Counters: col wraps at W-1 with row increment. The transfer at (H-1,W-1) moves to WAIT_FIN and deasserts pix_ready_o the next cycle.
- WAIT_FIN: count cycles.
  - acc_finish_i=1: latch the three means, go to DIV_R.
  - Count reaches TIMEOUT first: err_o pulse, go to IDLE, gains unchanged.
  - finish in the same cycle as the limit counts as success.
- DIV_R / DIV_B: restoring division of {g_mean,8'b0} (16 bits) by r_mean or b_mean, 16 iterations, one quotient bit per cycle, so 16 cycles each.
  - Quotient above 1023 saturates to 1023.
  - Divisor 0: gain=1023, state exits after 1 cycle.
  - Truncating division.
- DONE: r_gain_o/b_gain_o update, done_o=1 for one cycle, then IDLE.
- start_i outside IDLE is ignored; acc_finish_i outside WAIT_FIN is ignored.
- rst mid-operation: all state and outputs return to reset values immediately; the partially sent frame is abandoned. The next start re-clears the accumulator.
- Latency, good frame, no stalls, nonzero divisors: start to done = 1 + 1 + N + WAIT_FIN cycles + 32 + 1.

Test Plan:
- 4x4 frame (dims 2,2), all R=100, G=50, B=200, no stalls:
  - acc_size=2; 4 R, 4 G, 4 B samples; 3 acc_last pulses at the specified positions; Gb samples never valid.
  - With a model accumulator returning means 100/50/200: r_gain=128, b_gain=64, one done pulse.
- Same frame with pix_valid toggled 1-0-0 repeatedly -> identical acc_* sample sequence and gains; counters hold during gaps.
- Means R=10, G=200, B=0 -> r_gain=1023 (5120 saturated), b_gain=1023 via the divisor-zero path, DIV_B lasting 1 cycle.
- start with dims 12,12 (sum 24) -> err_o pulse, busy_o stays 0, acc_rst_n_o never pulses.
- acc_finish_i withheld -> err_o exactly 15 cycles after entering WAIT_FIN, return to IDLE, gains remain at their previous values.
- rst asserted mid-STREAM, then a new 4x4 frame -> all outputs at reset values during rst; the new frame produces a CLR pulse and the correct gains.
